segment_decoder: RTL
====================

// Module: segment_decoder
// PURPOSE
//  Reverse path of the 7-segment display driver: snoops a multiplexed, active-low seg/an bus
//  (on-board display or external pins), waits for each pattern to settle, decodes it back to
//  a digit per anode slot, and flags bad patterns.
//  Used as on-chip self-check of display output and as reader of an external display source.
// PARAMETERS
//  DIGITS         4    number of anode lines / digit slots (1..8)
//  STABLE_CYCLES  16   clk cycles {an,seg} must stay constant before capture (>=2)
//  CNT_W          8    stability counter width; must hold STABLE_CYCLES-1
// PORTS
//  clk          in   1          system clock
//  clr_n        in   1          synchronous reset, active-low
//  seg_in       in   7          segment bus {a,b,c,d,e,f,g}, 0 = lit
//  an_in        in   DIGITS     anode enables, 0 = digit active
//  digits_out   out  4*DIGITS   decoded value per slot, slot i at [4i+3:4i]; 4'hF = invalid
//  digit_valid  out  DIGITS     slot i captured at least once since reset (sticky)
//  frame_valid  out  1          all digit_valid bits set
//  capture      out  1          1-cycle pulse: a slot was written this cycle
//  invalid_pat  out  1          1-cycle pulse with capture when pattern not in table
//  multi_an     out  1          1-cycle pulse: stable window had >1 anode low (no capture)
// BEHAVIOUR
//  - Reset (clr_n=0 at posedge): all outputs 0; digits_out = 0; sync regs and prev = all ones
//    (blank bus); cnt = 0; state WAIT. Reset has priority over everything, incl. mid-window.
//  - Inputs pass a 2-flop synchroniser (s1 -> s2); prev <= s2 every cycle.
//  - FSM, 2 states, evaluated each posedge:
//    WAIT:     s2 != prev -> cnt <= 0, stay. Else cnt == STABLE_CYCLES-1 -> act, go HOLD;
//              else cnt <= cnt+1.
//    HOLD:     s2 != prev -> cnt <= 0, go WAIT; else stay (exactly one action per stable window).
//  - Action on WAIT->HOLD:
//    exactly one an bit low (slot i): digits_out[i] <= decode(seg), digit_valid[i] <= 1,
//    capture = 1, invalid_pat = 1 if decode gives F-invalid.
//    no an bit low (blank): no write, no pulse.  >1 low: no write, multi_an = 1.
//  - Latency: pins change before edge 1 and then hold -> capture at edge STABLE_CYCLES+3.
//    Any change inside window restarts count; a window shorter than that never captures.
//  - Decode table (seg -> value): 0000001->0 1001111->1 0010010->2 0000110->3 1001100->4
//    0100100->5 0100000->6 0001111->7 0000000->8 0000100->9; all else -> 4'hF + invalid_pat.
//  - Same slot re-captured overwrites; digit_valid never clears except by reset.
//  - frame_valid is combinational AND of digit_valid (registered sources, no extra delay).
//  - cnt saturates by construction (HOLD stops it); no wrap.
// CONFIGURATION
//  SEG_HEX_EN defined: additionally decode 0001000->A 1100000->b 0110001->C 1000010->d
//   0110000->E 0111000->F; these set no invalid_pat (value F from "F" pattern is valid; invalid
//   still reported via invalid_pat pulse, digits_out = 4'hF).
//  SEG_HEX_EN undefined: the six patterns above are invalid (4'hF + invalid_pat).
// STRUCTURE
//  - Shared header seg_pkg.vh: 7-bit pattern constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK,
//    INVALID_CODE (4'hF); shared with the display driver so both ends use one table.
//  - Sub-module seg7_to_bcd: combinational seg[6:0] -> {invalid, val[3:0]}, honours SEG_HEX_EN.
//  - Top: synchroniser, prev/compare, counter + FSM, one-hot anode check, slot register file.
// TESTING  (STABLE_CYCLES=16, DIGITS=4)
//  1 reset: clr_n=0 2 cycles with seg=0000000,an=1110 -> all outputs 0; no capture during reset.
//  2 an=1110, seg=0010010 held 40 cycles -> capture at edge 19, digits_out[3:0]=2,
//    digit_valid=0001; exactly one capture pulse.
//  3 cycle an 1110/1101/1011/0111 with 1,2,3,4 each 30 cycles -> digits_out=16'h4321,
//    frame_valid=1 after 4th capture.
//  4 seg toggles every 10 cycles on an=1110 -> no capture ever; 12-cycle glitch then stable
//    -> single capture 19 edges after last change.
//  5 an=1100 stable 30 cycles -> multi_an pulse once, no slot write; an=1111 -> nothing.
//  6 seg=0001000 on slot 1: without SEG_HEX_EN -> nibble F + invalid_pat; with -> nibble A,
//    no invalid_pat. Reset asserted at cnt=10 -> all cleared, no capture.

Source files
------------

// File: rtl/segment_decoder_pkg.sv
// Shared 7-segment pattern table (active-low {a,b,c,d,e,f,g}) and decoder types.
// Used by the display driver and by segment_decoder so both ends agree on one encoding.
package segment_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] INVALID_CODE = 4'hF;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic       invalid;
    logic [3:0] val;
  } seg_dec_t;

endpackage

// File: rtl/segment_decoder_seg7_to_bcd.sv
// Combinational 7-segment pattern -> digit value decoder.
// Define SEG_HEX_EN to also accept the hex letter patterns A..F.
module seg7_to_bcd
  import segment_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       invalid
);

  seg_dec_t dec;

  // Unknown patterns fall through to the invalid code with the flag raised.
  always_comb begin
    dec = '{invalid: 1'b1, val: INVALID_CODE};
    case (seg)
      SEG_0: dec = '{invalid: 1'b0, val: 4'h0};
      SEG_1: dec = '{invalid: 1'b0, val: 4'h1};
      SEG_2: dec = '{invalid: 1'b0, val: 4'h2};
      SEG_3: dec = '{invalid: 1'b0, val: 4'h3};
      SEG_4: dec = '{invalid: 1'b0, val: 4'h4};
      SEG_5: dec = '{invalid: 1'b0, val: 4'h5};
      SEG_6: dec = '{invalid: 1'b0, val: 4'h6};
      SEG_7: dec = '{invalid: 1'b0, val: 4'h7};
      SEG_8: dec = '{invalid: 1'b0, val: 4'h8};
      SEG_9: dec = '{invalid: 1'b0, val: 4'h9};
`ifdef SEG_HEX_EN
      SEG_A: dec = '{invalid: 1'b0, val: 4'hA};
      SEG_B: dec = '{invalid: 1'b0, val: 4'hB};
      SEG_C: dec = '{invalid: 1'b0, val: 4'hC};
      SEG_D: dec = '{invalid: 1'b0, val: 4'hD};
      SEG_E: dec = '{invalid: 1'b0, val: 4'hE};
      SEG_F: dec = '{invalid: 1'b0, val: 4'hF};
`endif
      default: ;
    endcase
  end

  assign val     = dec.val;
  assign invalid = dec.invalid;

endmodule

// File: rtl/segment_decoder.sv
// Snoops a multiplexed active-low seg/an bus, waits for each pattern to settle and
// decodes it back into one digit per anode slot. SEG_HEX_EN enables hex letter decode.
module segment_decoder
  import segment_decoder_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  capture,
  output logic                  invalid_pat,
  output logic                  multi_an
);

  localparam int              BUS_W    = DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [BUS_W-1:0]    sync1_q, sync1_d;
  logic [BUS_W-1:0]    sync2_q, sync2_d;
  logic [BUS_W-1:0]    prev_q, prev_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                capture_q, capture_d;
  logic                invalid_q, invalid_d;
  logic                multi_q, multi_d;

  logic                act;
  logic                bus_changed;
  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   an_low;
  logic                none_low;
  logic                one_low;
  logic [3:0]          dec_val;
  logic                dec_invalid;

  assign seg_s       = sync2_q[6:0];
  assign an_low      = ~sync2_q[BUS_W-1:7];
  assign bus_changed = (sync2_q != prev_q);
  assign none_low    = (an_low == '0);
  // Power-of-two test: clearing the lowest set bit leaves nothing when exactly one is low.
  assign one_low     = !none_low && ((an_low & (an_low - DIGITS'(1))) == '0);

  seg7_to_bcd u_seg7_to_bcd (
    .seg     (seg_s),
    .val     (dec_val),
    .invalid (dec_invalid)
  );

  // Settle detector: one action per window of STABLE_CYCLES unchanged comparisons.
  always_comb begin
    sync1_d = {an_in, seg_in};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    act     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (bus_changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          act     = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus_changed) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    capture_d = 1'b0;
    invalid_d = 1'b0;
    multi_d   = 1'b0;
    if (act) begin
      if (one_low) begin
        capture_d = 1'b1;
        invalid_d = dec_invalid;
        for (int i = 0; i < DIGITS; i++) begin
          if (an_low[i]) begin
            digits_d[4*i +: 4] = dec_val;
            valid_d[i]         = 1'b1;
          end
        end
      end else if (!none_low) begin
        multi_d = 1'b1;
      end
    end
  end

  // Reset loads a blank bus into the synchroniser so a blank display never captures.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      cnt_q     <= '0;
      state_q   <= ST_WAIT;
      digits_q  <= '0;
      valid_q   <= '0;
      capture_q <= 1'b0;
      invalid_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      capture_q <= capture_d;
      invalid_q <= invalid_d;
      multi_q   <= multi_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign frame_valid = &valid_q;
  assign capture     = capture_q;
  assign invalid_pat = invalid_q;
  assign multi_an    = multi_q;

endmodule
